// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, BTB entry layout, flush FSM states and
// the 2-bit direction counter encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // The tag field is sized for the smallest legal buffer (2 entries, so the
  // index is 1 bit). Larger buffers zero-fill the unused upper tag bits.
  // Those bits are constant, so they are optimised away.
  localparam int BTB_TAG_MAX_W = 29;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    word_t                    target;
    logic [1:0]               ctr;
  } btb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } flush_state_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup, EX/MEM update and flush/status bundle for the BTB.
// The master side is the pipeline and the slave side is the buffer.
interface branch_target_buffer_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
);
  word_t             lookup_pc;
  logic              lookup_hit;
  logic              lookup_taken;
  word_t             lookup_target;
  logic              upd_en;
  word_t             upd_pc;
  logic              upd_taken;
  word_t             upd_target;
  logic              flush;
  logic              flush_busy;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
    input  lookup_hit, lookup_taken, lookup_target, flush_busy, mispredict_cnt
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
    output lookup_hit, lookup_taken, lookup_target, flush_busy, mispredict_cnt
  );
endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating direction counter: next value from the current value
// and the resolved outcome.
module sat_counter2
  import cpu_types_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       taken,
  output logic [1:0] ctr_next
);
  // Step toward strong-taken or strong-not-taken, holding at either end.
  always_comb begin
    ctr_next = ctr_in;
    if (taken) begin
      if (ctr_in != CTR_STRONG_T) ctr_next = ctr_in + 2'd1;
    end else begin
      if (ctr_in != CTR_STRONG_NT) ctr_next = ctr_in - 2'd1;
    end
  end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. Lookup is zero-latency from the
// registered entries. Training comes from resolved branches. A flush walks
// the entries and invalidates one per cycle. Mispredictions are counted
// with saturation.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  branch_target_buffer_if.slave bus
);

  btb_entry_t       entries [ENTRIES];
  flush_state_t     state_reg;
  logic [IDX_W-1:0] walk_idx_reg;
  logic             flush_busy_reg;
  logic [CNT_W-1:0] mispredict_reg;

  function automatic logic [BTB_TAG_MAX_W-1:0] tag_of(input word_t pc);
    return BTB_TAG_MAX_W'(pc >> (IDX_W + 2));
  endfunction

  // PC bits [1:0] are always zero for word-aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] lk_idx;
  btb_entry_t       lk_entry;
  logic             lk_match;

  assign lk_idx   = bus.lookup_pc[IDX_W+1:2];
  assign lk_entry = entries[lk_idx];
  assign lk_match = lk_entry.valid && (lk_entry.tag == tag_of(bus.lookup_pc))
                    && !flush_busy_reg;

  assign bus.lookup_hit    = lk_match;
  assign bus.lookup_taken  = lk_match && lk_entry.ctr[1];
  assign bus.lookup_target = lk_match ? lk_entry.target : '0;

  // ---------------- update ----------------
  logic [IDX_W-1:0] upd_idx;
  btb_entry_t       upd_entry;
  btb_entry_t       upd_new;
  logic             upd_hit;
  logic             upd_pred;
  logic             upd_accept;
  logic             upd_write;
  logic [1:0]       ctr_next;

  assign upd_idx    = bus.upd_pc[IDX_W+1:2];
  assign upd_entry  = entries[upd_idx];
  assign upd_hit    = upd_entry.valid && (upd_entry.tag == tag_of(bus.upd_pc));
  assign upd_pred   = upd_hit && upd_entry.ctr[1];
  assign upd_accept = bus.upd_en && !flush_busy_reg;
  // A not-taken branch that misses never allocates.
  assign upd_write  = upd_accept && (upd_hit || bus.upd_taken);

  sat_counter2 u_sat_counter2 (
    .ctr_in   (upd_entry.ctr),
    .taken    (bus.upd_taken),
    .ctr_next (ctr_next)
  );

  // Build the entry to write: train on a hit, or allocate weak-taken on a miss.
  always_comb begin
    upd_new       = upd_entry;
    upd_new.valid = 1'b1;
    if (upd_hit) begin
      upd_new.ctr = ctr_next;
      if (bus.upd_taken) upd_new.target = bus.upd_target;
    end else begin
      upd_new.tag    = tag_of(bus.upd_pc);
      upd_new.target = bus.upd_target;
      upd_new.ctr    = CTR_WEAK_T;
    end
  end

  // ---------------- entry storage ----------------
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    btb_entry_t entry_reg;

    // Reset clears the entry. The flush walk then invalidates it. Otherwise an
    // accepted update writes it.
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (state_reg == WALK) begin
        if (walk_idx_reg == IDX_W'(gi)) entry_reg.valid <= 1'b0;
      end else if (upd_write && (upd_idx == IDX_W'(gi))) begin
        entry_reg <= upd_new;
      end
    end

    assign entries[gi] = entry_reg;
  end

  // ---------------- flush FSM ----------------
  // IDLE waits for a flush pulse. WALK visits every index once, then returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      walk_idx_reg   <= '0;
      flush_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.flush) begin
            state_reg      <= WALK;
            walk_idx_reg   <= '0;
            flush_busy_reg <= 1'b1;
          end
        end
        WALK: begin
          walk_idx_reg <= walk_idx_reg + 1'b1;
          if (walk_idx_reg == IDX_W'(ENTRIES - 1)) begin
            state_reg      <= IDLE;
            flush_busy_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          flush_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  // Count updates whose prediction disagreed with the outcome, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_reg <= '0;
    end else if (upd_accept && (upd_pred != bus.upd_taken) && (mispredict_reg != '1)) begin
      mispredict_reg <= mispredict_reg + 1'b1;
    end
  end

  assign bus.flush_busy     = flush_busy_reg;
  assign bus.mispredict_cnt = mispredict_reg;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scoreboard bench for branch_target_buffer (ENTRIES=16). The
// stimulus queues the outputs expected in each driven cycle. The monitor
// compares those outputs on the falling edge.
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_target_buffer_if #(.CNT_W(16)) bus ();

  branch_target_buffer #(.ENTRIES(16), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    int          cyc;
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string nm, input logic [31:0] lpc,
                      input logic ue, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic fl, input logic r,
                      input logic eh, input logic et, input logic [31:0] etgt,
                      input logic eb, input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    bus.lookup_pc  = lpc;
    bus.upd_en     = ue;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utgt;
    bus.flush      = fl;
    rst            = r;
    e.nm = nm; e.cyc = cyc; e.hit = eh; e.tk = et; e.tgt = etgt; e.busy = eb; e.cnt = ecnt;
    q.push_back(e);
  endtask

  task automatic look(input string nm, input logic [31:0] lpc, input logic eh,
                      input logic et, input logic [31:0] etgt, input logic eb,
                      input logic [15:0] ecnt);
    step(nm, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, eh, et, etgt, eb, ecnt);
  endtask

  // Monitor: pop every expectation queued for this cycle and compare.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.lookup_hit !== e.hit || bus.lookup_taken !== e.tk ||
          bus.lookup_target !== e.tgt || bus.flush_busy !== e.busy ||
          bus.mispredict_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got hit=%b taken=%b target=%h busy=%b cnt=%0d, want hit=%b taken=%b target=%h busy=%b cnt=%0d",
                 e.nm, bus.lookup_hit, bus.lookup_taken, bus.lookup_target, bus.flush_busy,
                 bus.mispredict_cnt, e.hit, e.tk, e.tgt, e.busy, e.cnt);
      end else begin
        $display("ok   %s: hit=%b taken=%b target=%h busy=%b cnt=%0d",
                 e.nm, e.hit, e.tk, e.tgt, e.busy, e.cnt);
      end
    end
  end

  logic [31:0] walk_pcs [4];

  initial begin
    walk_pcs[0] = 32'h40; walk_pcs[1] = 32'h44; walk_pcs[2] = 32'h48; walk_pcs[3] = 32'h4C;
    rst = 1'b1;
    bus.lookup_pc = '0; bus.upd_en = 1'b0; bus.upd_pc = '0;
    bus.upd_taken = 1'b0; bus.upd_target = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);

    look("reset", 32'h40, 0, 0, 32'h0, 0, 0);
    step("alloc", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 32'h0, 0, 0);
    step("tk1", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 0, 1);
    step("tk2", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 0, 1);
    step("tk3", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 0, 1);
    step("tk4", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 0, 1);
    look("ctr_sat_hi", 32'h40, 1, 1, 32'h100, 0, 1);
    // Step 11 down to 10. This is a mispredict because strong-taken predicted taken.
    step("nt_to_10", 32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 1, 1, 32'h100, 0, 1);
    step("nt_to_01", 32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 1, 1, 32'h100, 0, 2);
    step("nt_to_00", 32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 1, 0, 32'h100, 0, 3);
    step("nt_miss", 32'h44, 1, 32'h44, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 3);
    look("no_alloc", 32'h44, 0, 0, 32'h0, 0, 3);
    look("ctr_sat_lo", 32'h40, 1, 0, 32'h100, 0, 3);
    // 0x80 aliases 0x40: both use index 0, with tags 2 and 1.
    step("alias_miss", 32'h80, 1, 32'h80, 1, 32'h200, 0, 0, 0, 0, 32'h0, 0, 3);
    look("alias_hit", 32'h80, 1, 1, 32'h200, 0, 4);
    look("alias_evict", 32'h40, 0, 0, 32'h0, 0, 4);
    step("realloc", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 32'h0, 0, 4);
    step("same_cyc", 32'h40, 1, 32'h40, 1, 32'h300, 0, 0, 1, 1, 32'h100, 0, 5);
    look("same_after", 32'h40, 1, 1, 32'h300, 0, 5);
    step("fill1", 32'h44, 1, 32'h44, 1, 32'h400, 0, 0, 0, 0, 32'h0, 0, 5);
    step("fill2", 32'h48, 1, 32'h48, 1, 32'h480, 0, 0, 0, 0, 32'h0, 0, 6);
    step("fill3", 32'h4C, 1, 32'h4C, 1, 32'h4C0, 0, 0, 0, 0, 32'h0, 0, 7);
    step("flush_go", 32'h44, 0, 32'h0, 0, 32'h0, 1, 0, 1, 1, 32'h400, 0, 8);
    // Walk cycles: an update at 3 and 10 must be dropped, and a flush at 5 ignored.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("walk%0d", i), walk_pcs[i % 4], (i == 3 || i == 10),
           (i == 3) ? 32'h40 : 32'h50, (i == 10), 32'h999, (i == 5), 0,
           0, 0, 32'h0, 1, 8);
    end
    look("post_40", 32'h40, 0, 0, 32'h0, 0, 8);
    look("post_44", 32'h44, 0, 0, 32'h0, 0, 8);
    look("post_48", 32'h48, 0, 0, 32'h0, 0, 8);
    look("post_4c", 32'h4C, 0, 0, 32'h0, 0, 8);
    look("post_50", 32'h50, 0, 0, 32'h0, 0, 8);
    step("fill_7c", 32'h7C, 1, 32'h7C, 1, 32'h7C0, 0, 0, 0, 0, 32'h0, 0, 8);
    look("hit_7c", 32'h7C, 1, 1, 32'h7C0, 0, 9);
    // A flush and an update in the same idle cycle: the update lands first.
    step("flush_upd", 32'h40, 1, 32'h40, 1, 32'h500, 1, 0, 0, 0, 32'h0, 0, 9);
    for (int i = 0; i < 5; i++) begin
      look($sformatf("walk2_%0d", i), 32'h7C, 0, 0, 32'h0, 1, 10);
    end
    step("rst_in_walk", 32'h7C, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 10);
    look("rst_7c", 32'h7C, 0, 0, 32'h0, 0, 0);
    look("rst_40", 32'h40, 0, 0, 32'h0, 0, 0);
    look("rst_44", 32'h44, 0, 0, 32'h0, 0, 0);

    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    bus.flush  = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
